// File: rtl/pwm_fade_sequencer_pkg.sv
// Shared definitions for the PWM fade sequencer.
// Holds the channel count, the register map, the CTRL bit positions and the
// scan FSM state encoding. The top module and the bench both import it.
package pwm_fade_sequencer_pkg;

    localparam int unsigned NUM_CH = 8;

    // Register map
    localparam logic [7:0] TARGET_BASE = 8'h00;  // TARGET[0..NUM_CH-1]
    localparam logic [7:0] RATE_ADDR   = 8'h08;
    localparam logic [7:0] CTRL_ADDR   = 8'h09;
    localparam logic [7:0] STATUS_ADDR = 8'h0A;

    // CTRL register layout
    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_INSTANT_BIT = 1;
    localparam logic [1:0]  CTRL_RESET       = 2'b01;  // EN=1, INSTANT=0

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/pwm_fade_sequencer_prescaler.sv
// Fade step prescaler.
// Counts clocks while enabled and emits a one-cycle step pulse when the
// count equals {rate, all-ones low bits}; the counter wraps to 0 on that edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable; when low the counter is held at 0
//   rate       : step period select, period = (rate+1) * 2^PRESC_LSB_W clocks
//   step       : one-cycle step pulse
module fade_prescaler #(
    parameter int unsigned PRESC_LSB_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] rate,
    output logic       step
);

    localparam int unsigned CNT_W = 8 + PRESC_LSB_W;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit;

    assign limit = {rate, {PRESC_LSB_W{1'b1}}};

    // Only an exact match fires a step: after a RATE decrease below the
    // current count, the counter runs through all-ones and wraps silently.
    always_comb begin
        step  = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == limit) begin
            step  = 1'b1;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// PWM fade sequencer.
// Register file written from the I2C application interface; on every
// prescaler step a scan walks the channels one per clock and moves each
// level one count toward its target.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wen        : one-cycle register write strobe
//   addr       : register address for write and read
//   wdata      : write data
//   rdata      : combinational read data for addr
//   level      : current duty per channel, channel i on [8i+7:8i]
//   busy       : high while any level differs from its target
module pwm_fade_sequencer #(
    parameter int unsigned NUM_CH      = pwm_fade_sequencer_pkg::NUM_CH,
    parameter int unsigned PRESC_LSB_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wen,
    input  logic [7:0]          addr,
    input  logic [7:0]          wdata,
    output logic [7:0]          rdata,
    output logic [8*NUM_CH-1:0] level,
    output logic                busy
);

    import pwm_fade_sequencer_pkg::*;

    localparam int unsigned     IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    fsm_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        level_q  [NUM_CH];
    logic [7:0]        level_d  [NUM_CH];
    logic [7:0]        target_q [NUM_CH];
    logic [7:0]        target_d [NUM_CH];
    logic [7:0]        rate_q, rate_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              en;
    logic              instant;
    logic              step;
    logic [NUM_CH-1:0] busy_mask;

    assign en      = ctrl_q[CTRL_EN_BIT];
    assign instant = ctrl_q[CTRL_INSTANT_BIT];

    fade_prescaler #(
        .PRESC_LSB_W(PRESC_LSB_W)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .rate (rate_q),
        .step (step)
    );

    // Scan FSM. A step arriving mid-scan is ignored.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (step) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                    end
                end
                ST_SCAN: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Level datapath and register writes. The scan compares against the
    // registered target, so a same-cycle target write is seen next visit;
    // an INSTANT load is applied last so it overrides the scan update.
    always_comb begin
        level_d  = level_q;
        target_d = target_q;
        rate_d   = rate_q;
        ctrl_d   = ctrl_q;

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (en && (state_q == ST_SCAN) && (idx_q == IDX_W'(i))) begin
                if (level_q[i] < target_q[i]) begin
                    level_d[i] = level_q[i] + 8'd1;
                end else if (level_q[i] > target_q[i]) begin
                    level_d[i] = level_q[i] - 8'd1;
                end
            end
        end

        if (wen) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (addr == (TARGET_BASE + 8'(i))) begin
                    target_d[i] = wdata;
                    if (instant) begin
                        level_d[i] = wdata;
                    end
                end
            end
            if (addr == RATE_ADDR) begin
                rate_d = wdata;
            end
            if (addr == CTRL_ADDR) begin
                ctrl_d = wdata[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rate_q  <= '0;
            ctrl_q  <= CTRL_RESET;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                level_q[i]  <= '0;
                target_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rate_q   <= rate_d;
            ctrl_q   <= ctrl_d;
            level_q  <= level_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        level     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            busy_mask[i]     = (level_q[i] != target_q[i]);
            level[8*i +: 8]  = level_q[i];
        end
    end

    assign busy = |busy_mask;

    always_comb begin
        rdata = '0;
        case (addr)
            RATE_ADDR:   rdata = rate_q;
            CTRL_ADDR:   rdata = {6'b0, ctrl_q};
            STATUS_ADDR: rdata = 8'(busy_mask);
            default:     rdata = '0;
        endcase
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (addr == (TARGET_BASE + 8'(i))) begin
                rdata = level_q[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench for pwm_fade_sequencer: register-map vector table,
// directed fade/reset sequences and random traffic against a reference model.
module tb_pwm_fade_sequencer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen   = 1'b0;
    logic [7:0]  addr  = 8'h00;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic [63:0] level;
    logic        busy;

    always #5 clk = ~clk;

    pwm_fade_sequencer #(
        .NUM_CH     (8),
        .PRESC_LSB_W(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wen  (wen),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .level(level),
        .busy (busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    int m_level [8];
    int m_target[8];
    int m_rate;
    int m_cnt;       // clocks counted in the current step period
    int m_scan;      // channel to be visited at the next edge, -1 when idle
    bit m_en;
    bit m_inst;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_level[i]  = 0;
            m_target[i] = 0;
        end
        m_rate = 0;
        m_cnt  = 0;
        m_scan = -1;
        m_en   = 1'b1;
        m_inst = 1'b0;
    endtask

    task automatic model_edge(input bit w, input int a, input int d);
        int period_end;
        bit fire;
        int ch;
        period_end = m_rate * 256 + 255;
        fire = m_en && (m_cnt == period_end);
        if (m_en) begin
            if (m_scan >= 0) begin
                ch = m_scan;
                if (m_level[ch] < m_target[ch]) m_level[ch] = m_level[ch] + 1;
                else if (m_level[ch] > m_target[ch]) m_level[ch] = m_level[ch] - 1;
                m_scan = (ch == 7) ? -1 : ch + 1;
            end else if (fire) begin
                m_scan = 0;
            end
            m_cnt = fire ? 0 : (m_cnt + 1) % 65536;
        end else begin
            m_cnt  = 0;
            m_scan = -1;
        end
        if (w) begin
            if (a < 8) begin
                m_target[a] = d;
                if (m_inst) m_level[a] = d;
            end else if (a == 8) begin
                m_rate = d;
            end else if (a == 9) begin
                m_en   = d[0];
                m_inst = d[1];
            end
        end
    endtask

    function automatic logic [63:0] m_flat();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(m_level[i]);
        return r;
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = (m_level[i] != m_target[i]);
        return r;
    endfunction

    function automatic logic [7:0] m_rdata(input int a);
        if (a < 8)  return 8'(m_level[a]);
        if (a == 8) return 8'(m_rate);
        if (a == 9) return {6'b0, m_inst, m_en};
        if (a == 10) return m_mask();
        return 8'h00;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: inputs applied at the falling edge, model stepped at the
    // rising edge, returns at the next falling edge.
    task automatic cyc(input logic w, input logic [7:0] a, input logic [7:0] d);
        wen   = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_edge(w, int'(a), int'(d));
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, addr, 8'h00);
    endtask

    task automatic chk_model(input string name);
        check({name, " level"}, level, m_flat());
        check({name, " busy"}, 64'(busy), 64'(m_mask() != 8'h00));
        check({name, " rdata"}, 64'(rdata), 64'(m_rdata(int'(addr))));
    endtask

    task automatic wait_change(input string name, input int ch, input int bound,
                               output int n);
        logic [7:0] prev;
        bit ok;
        prev = level[8*ch +: 8];
        ok   = 1'b0;
        n    = 0;
        while (n < bound && !ok) begin
            cyc(1'b0, addr, 8'h00);
            n++;
            if (level[8*ch +: 8] != prev) ok = 1'b1;
        end
        check({name, " change seen"}, 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- register vector table ----------------
    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] ra;
        logic [7:0] er;
        logic       eb;
    } vec_t;

    vec_t vecs[15];
    int   nc, c1, c2;
    logic [63:0] snap;
    int   r;
    logic [7:0] ra, rd;

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h09, 8'h01, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h08, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 8'h09, 8'h02, 8'h09, 8'h02, 1'b0};  // EN=0 INSTANT=1
        vecs[4]  = '{1'b1, 8'h08, 8'h5A, 8'h08, 8'h5A, 1'b0};
        vecs[5]  = '{1'b1, 8'h02, 8'h40, 8'h02, 8'h40, 1'b0};  // instant load
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h0A, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 8'h0B, 8'hFF, 8'h0B, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 8'h0A, 8'hFF, 8'h0A, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 8'h09, 8'hFF, 8'h09, 8'h03, 1'b0};
        vecs[10] = '{1'b1, 8'h09, 8'h00, 8'h09, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 8'h05, 8'h33, 8'h05, 8'h00, 1'b1};  // target only
        vecs[12] = '{1'b0, 8'h00, 8'h00, 8'h0A, 8'h20, 1'b1};
        vecs[13] = '{1'b1, 8'h05, 8'h00, 8'h0A, 8'h00, 1'b0};
        vecs[14] = '{1'b1, 8'h08, 8'h00, 8'h08, 8'h00, 1'b0};

        model_reset();
        @(negedge clk);
        do_reset();

        // Reset state
        check("reset level", level, 64'h0);
        check("reset busy", 64'(busy), 64'd0);
        addr = 8'h09; #1;
        check("reset ctrl", 64'(rdata), 64'h01);
        addr = 8'h08; #1;
        check("reset rate", 64'(rdata), 64'h00);

        // Register map vectors
        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].w, vecs[i].a, vecs[i].d);
            addr = vecs[i].ra;
            #1;
            check($sformatf("vec%0d rdata", i), 64'(rdata), 64'(vecs[i].er));
            check($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].eb));
        end
        chk_model("after table");

        // Single-channel fade at RATE=0
        @(negedge clk);
        do_reset();
        cyc(1'b1, 8'h03, 8'h05);
        addr = 8'h0A; #1;
        check("fade start busy", 64'(busy), 64'd1);
        check("fade start status", 64'(rdata), 64'h08);
        nc = 0;
        while (nc < 3000 && level[31:24] != 8'h05) begin
            cyc(1'b0, addr, 8'h00);
            nc++;
        end
        check("fade5 reached", 64'(level[31:24] == 8'h05), 64'd1);
        check("fade5 latency window", 64'(nc >= 1024 && nc <= 1536), 64'd1);
        check("fade5 levels", level, 64'h0000_0000_0500_0000);
        check("fade5 busy", 64'(busy), 64'd0);
        chk_model("fade5");

        // Downward fade and floor
        cyc(1'b1, 8'h09, 8'h03);
        cyc(1'b1, 8'h00, 8'h10);
        cyc(1'b1, 8'h09, 8'h01);
        check("down preload", 64'(level[7:0]), 64'h10);
        cyc(1'b1, 8'h00, 8'h0E);
        wait_change("down1", 0, 600, c1);
        check("down first", 64'(level[7:0]), 64'h0F);
        wait_change("down2", 0, 600, c1);
        check("down second", 64'(level[7:0]), 64'h0E);
        run(600);
        check("down hold", 64'(level[7:0]), 64'h0E);
        cyc(1'b1, 8'h01, 8'h00);
        run(600);
        check("floor no underflow", 64'(level[15:8]), 64'h00);
        chk_model("down");

        // Instant load
        cyc(1'b1, 8'h09, 8'h03);
        cyc(1'b1, 8'h07, 8'hAA);
        check("instant level7", 64'(level[63:56]), 64'hAA);
        check("instant busy", 64'(busy), 64'd0);
        chk_model("instant");
        cyc(1'b1, 8'h09, 8'h01);

        // Pause and resume at RATE=1
        cyc(1'b1, 8'h08, 8'h01);
        cyc(1'b1, 8'h04, 8'h80);
        run(1100);
        check("rate1 fading", 64'(level[39:32] != 8'h00), 64'd1);
        chk_model("rate1");
        cyc(1'b1, 8'h09, 8'h00);
        snap = level;
        run(2100);
        check("paused frozen", level, snap);
        chk_model("paused");
        cyc(1'b1, 8'h09, 8'h01);
        wait_change("resume1", 4, 1500, c1);
        wait_change("resume2", 4, 1500, c2);
        check("resume step spacing", 64'(c2), 64'd512);
        chk_model("resume");

        // Reset in the middle of a scan
        cyc(1'b1, 8'h08, 8'h00);
        cyc(1'b1, 8'h09, 8'h03);
        cyc(1'b1, 8'h02, 8'h40);
        cyc(1'b1, 8'h00, 8'h00);
        cyc(1'b1, 8'h09, 8'h01);
        cyc(1'b1, 8'h00, 8'h30);
        wait_change("scan entry", 0, 1000, c1);
        check("pre-reset level2", 64'(level[23:16]), 64'h40);
        #2 rst_n = 1'b0;
        #1;
        check("async reset level", level, 64'h0);
        check("async reset busy", 64'(busy), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        addr = 8'h0B; #1;
        check("read 0x0B", 64'(rdata), 64'h00);
        cyc(1'b1, 8'h0B, 8'h55);
        chk_model("write 0x0B");
        cyc(1'b1, 8'h02, 8'h03);
        wait_change("post reset step", 2, 400, c1);
        check("post reset level2", 64'(level[23:16]), 64'h01);
        chk_model("post reset");

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            r  = $urandom_range(0, 99);
            ra = 8'($urandom_range(0, 15));
            rd = 8'($urandom_range(0, 255));
            if (r < 4) begin
                if (ra == 8'h08) rd = 8'($urandom_range(0, 1));
                if (ra == 8'h09) begin
                    if ($urandom_range(0, 7) == 0) rd = 8'h00;
                    else if ($urandom_range(0, 3) == 0) rd = 8'h03;
                    else rd = 8'h01;
                end
                cyc(1'b1, ra, rd);
            end else begin
                cyc(1'b0, ra, 8'h00);
            end
            if (i % 8 == 7) chk_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_fade_sequencer.md
PWM_FADE_SEQUENCER -- requirements
Module: pwm_fade_sequencer

Interface
REQ-001: Parameter NUM_CH, default 8, number of PWM channels sequenced; fixed at 8 for this design.
REQ-002: Parameter PRESC_LSB_W, default 8, low prescaler bits; one rate unit equals 256 clocks.
REQ-003: clk  input  1  single clock; all state on rising edge.
REQ-004: rst_n  input  1  asynchronous active-low reset.
REQ-005: wen  input  1  one-cycle register write strobe from the I2C application interface.
REQ-006: addr  input  8  register address for write and read.
REQ-007: wdata  input  8  write data, valid when wen=1.
REQ-008: rdata  output  8  combinational read data for addr.
REQ-009: level  output  64  current duty per channel, channel i on bits [8i+7:8i], feeds pwm_channel value inputs.
REQ-010: busy  output  1  high while any level differs from its target.

Function
REQ-011: Register map: 0x00-0x07 TARGET[i] (R: current level[i]); 0x08 RATE (R/W); 0x09 CTRL (bit0 EN, bit1 INSTANT; bits 7:2 read 0); 0x0A STATUS (R: per-channel busy mask, writes ignored); other addresses write-ignored, read 0x00.
REQ-012: Prescaler: 16-bit counter; increments each clock while EN=1; when equal to {RATE,8'hFF} it asserts a one-cycle step pulse and wraps to 0 on the same edge.
REQ-013: EN=0: prescaler forced to 0, FSM forced to IDLE next edge, levels hold, target writes still accepted.
REQ-014: FSM states IDLE, SCAN; IDLE->SCAN on step pulse with channel index 0; SCAN visits index 0..7, one channel per clock; SCAN->IDLE after index 7.
REQ-015: In SCAN at index i: level[i] += 1 if level[i] < target[i]; level[i] -= 1 if level[i] > target[i]; else unchanged; no wrap past 0x00 or 0xFF.
REQ-016: Step pulse arriving in SCAN is dropped (unreachable for RATE>=0, as step period >=256 > 8 clocks).
REQ-017: Scan comparison uses the target value registered before the current edge; a simultaneous write to target[i] takes effect from the next visit.
REQ-018: Write to TARGET[i] with INSTANT=1 also loads level[i] <= wdata on the same edge, overriding any scan update to level[i] in that cycle.
REQ-019: Write to RATE takes effect immediately; if the counter already exceeds the new limit, it continues to 0xFFFF, wraps to 0, and no step fires on the wrap.
REQ-020: busy and STATUS are combinational from registered level/target; level is a register output with no combinational path from inputs.
REQ-021: Full fade latency 0x00->0xFF = 255 steps x (RATE+1) x 256 clocks, +/- one step period.

Reset
REQ-022: On rst_n low, asynchronously: level[*]=0x00, target[*]=0x00, RATE=0x00, CTRL=0x01 (EN=1, INSTANT=0), prescaler=0, FSM=IDLE, index=0; busy=0.
REQ-023: Reset asserted mid-SCAN abandons the scan with no partial state retained; operation resumes from the first step after release.

Structure
REQ-024: Shared package holds NUM_CH, register address constants (TARGET_BASE, RATE_ADDR, CTRL_ADDR, STATUS_ADDR), CTRL bit positions, and FSM state encoding.
REQ-025: Prescaler is a sub-module fade_prescaler (clk, rst_n, en, rate, step); register file, FSM and level datapath are in the top.

Verification
REQ-026: Reset, no writes -> level=0, busy=0, rdata@0x09=0x01, rdata@0x08=0x00.
REQ-027: RATE=0, write TARGET[3]=0x05 -> busy=1; level[3] reaches 0x05 after 5 steps (~1280 clocks), then busy=0; other channels stay 0.
REQ-028: level[0]=0x10, write TARGET[0]=0x0E -> decrements 0x0F, 0x0E, then holds; no underflow with TARGET=0x00 from level 0x00.
REQ-029: CTRL=0x03, write TARGET[7]=0xAA -> level[7]=0xAA next clock, busy unchanged (0).
REQ-030: RATE=1, mid-fade write CTRL=0x00 -> levels frozen for >=2048 clocks; CTRL=0x01 -> fade resumes, step spacing 512 clocks.
REQ-031: Assert rst_n during SCAN with level[2]=0x40 -> all levels 0x00 asynchronously; read of 0x0B and write to 0x0B have no effect.
